cic_decimator: RTL and testbench

CIC_DECIMATOR -- requirements
Module: cic_decimator

---
 rtl/cic_pkg.sv | 22 ++
 rtl/cic_integrator.sv | 25 ++
 rtl/cic_decimator.sv | 85 ++++++++
 tb/tb_cic_decimator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared CIC helpers: log2 sizing and full accumulator width.
// Used by cic_decimator and any downstream comb section.
package cic_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) begin
      r++;
    end
    return r;
  endfunction

  function automatic int width_full(
    input int win,
    input int stages,
    input int rate
  );
    return win + stages * clog2(rate);
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: wrapping accumulator with enable.
// Sync active-high reset clears the accumulator.
module cic_integrator #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_acc
);

  logic [W-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + i_din;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cic_decimator.sv
// CIC integrator chain with decimating output register.
// Define CIC_DECIMATOR_ROUND_EN for round-half-up output.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int WIDTH_IN  = 12,
  parameter int STAGES    = 3,
  parameter int RATE      = 8,
  parameter int WIDTH_OUT = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_IN-1:0]  x,
  input  logic                 x_valid,
  output logic [WIDTH_OUT-1:0] y,
  output logic                 y_valid
);

  localparam int WF = width_full(WIDTH_IN, STAGES, RATE);
  localparam int CW = clog2(RATE);
  localparam int SH = WF - WIDTH_OUT;
  localparam logic [CW-1:0] LAST = CW'(RATE - 1);

  logic [STAGES:0][WF-1:0] w_in;
  logic [WF-1:0]           w_last_nxt;
  logic [WF-1:0]           w_sel;
  logic [WIDTH_OUT-1:0]    w_y;
  logic [CW-1:0]           r_cnt;
  logic [WIDTH_OUT-1:0]    r_y;
  logic                    r_yv;

  assign w_in[0] = {{(WF - WIDTH_IN){x[WIDTH_IN-1]}}, x};

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_int
    cic_integrator #(
      .W(WF)
    ) u_int (
      .clk  (clk),
      .rst  (rst),
      .i_en (x_valid),
      .i_din(w_in[k]),
      .o_acc(w_in[k+1])
    );
  end

  // Post-update value of the last stage, seen before the edge
  assign w_last_nxt = w_in[STAGES] + w_in[STAGES-1];

`ifdef CIC_DECIMATOR_ROUND_EN
  if (SH > 0) begin : g_rnd
    localparam logic [WF-1:0] HALF = WF'(1) << (SH - 1);
    assign w_sel = w_last_nxt + HALF;
  end else begin : g_nornd
    assign w_sel = w_last_nxt;
  end
`else
  assign w_sel = w_last_nxt;
`endif

  assign w_y = WIDTH_OUT'(w_sel >> SH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_y   <= '0;
      r_yv  <= 1'b0;
    end else begin
      r_yv <= 1'b0;
      if (x_valid) begin
        if (r_cnt == LAST) begin
          r_cnt <= '0;
          r_y   <= w_y;
          r_yv  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign y       = r_y;
  assign y_valid = r_yv;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: full-width and 12-bit
// instances share stimulus; a negedge monitor pops expectations.
module tb_cic_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] x = '0;
  logic        x_valid = 1'b0;
  logic [20:0] ya;
  logic        yva;
  logic [11:0] yb;
  logic        yvb;

  int total = 0;
  int bad = 0;
  int n = 0;
  bit auto_exp = 1'b0;
  logic [11:0] auto_x = '0;

  logic [20:0] qa[$];
  logic [11:0] qb[$];

  always #5 clk = ~clk;

  cic_decimator #(
    .WIDTH_IN(12), .STAGES(3), .RATE(8), .WIDTH_OUT(21)
  ) dut_a (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
    .y(ya), .y_valid(yva)
  );

  cic_decimator #(
    .WIDTH_IN(12), .STAGES(3), .RATE(8), .WIDTH_OUT(12)
  ) dut_b (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
    .y(yb), .y_valid(yvb)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to12(input logic [20:0] f);
    logic [20:0] t;
    t = f;
`ifdef CIC_DECIMATOR_ROUND_EN
    t = t + 21'd256;
`endif
    return t[20:9];
  endfunction

  function automatic void expect_y(input logic [20:0] f);
    qa.push_back(f);
    qb.push_back(to12(f));
  endfunction

  // Closed form of a 3-stage integrator under constant input
  function automatic logic [20:0] model(input int cnt,
                                        input logic [11:0] xv);
    longint c;
    longint v;
    c = longint'(cnt) * (cnt - 1) * (cnt - 2) / 6;
    v = c * longint'($signed(xv));
    return v[20:0];
  endfunction

  task automatic step(input logic [11:0] xv, input bit v);
    @(posedge clk);
    #1;
    x = xv;
    x_valid = v;
    if (v && !rst) begin
      n++;
      if (auto_exp && (n % 8 == 0)) expect_y(model(n, auto_x));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    x = 12'd1;
    x_valid = 1'b1;
    n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    x_valid = 1'b0;
    @(negedge clk);
    check("rst_ya", ya, 0);
    check("rst_yva", yva, 0);
    check("rst_yb", yb, 0);
    check("rst_yvb", yvb, 0);
  endtask

  task automatic drain();
    step(12'd0, 1'b0);
    for (int i = 0; i < 40 && (qa.size() + qb.size()) != 0; i++)
      @(negedge clk);
    check("drain", qa.size() + qb.size(), 0);
  endtask

  int since = 0;
  logic [20:0] la = '0;
  logic [11:0] lb = '0;

  always @(negedge clk) begin
    if (rst) begin
      since = 0;
      la = '0;
      lb = '0;
    end else begin
      check("yv_known", 32'($isunknown({yva, yvb})), 0);
      check("strobe_match", yva, yvb);
      if (yva === 1'b1) begin
        check("spacing", since, 8);
        since = 0;
        if (qa.size() == 0) begin
          check("unexpected_y_a", ya, la);
          check("unexpected_y_a_qempty", 1, 0);
        end else begin
          check("y_a", ya, qa.pop_front());
        end
        la = ya;
      end else begin
        check("hold_a", ya, la);
      end
      if (yvb === 1'b1) begin
        if (qb.size() == 0) begin
          check("unexpected_y_b_qempty", 1, 0);
        end else begin
          check("y_b", yb, qb.pop_front());
        end
        lb = yb;
      end else begin
        check("hold_b", yb, lb);
      end
      if (x_valid) since++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // DC +1: C(8,3)=56, C(16,3)=560
    expect_y(21'd56);
    expect_y(21'd560);
    repeat (16) step(12'd1, 1'b1);
    drain();

    // DC -1
    do_reset();
    expect_y(21'h1FFFC8);
    repeat (8) step(12'hFFF, 1'b1);
    drain();

    // Strobe every third cycle, junk on x during gaps
    do_reset();
    expect_y(21'd56);
    repeat (8) begin
      step(12'd1, 1'b1);
      step(12'h555, 1'b0);
      step(12'hAAA, 1'b0);
    end
    drain();

    // x=100: full 5600 -> 10 truncated, 11 rounded
    do_reset();
    qa.push_back(21'd5600);
`ifdef CIC_DECIMATOR_ROUND_EN
    qb.push_back(12'd11);
`else
    qb.push_back(12'd10);
`endif
    repeat (8) step(12'd100, 1'b1);
    drain();

    // Mid-frame reset discards 5 samples
    do_reset();
    repeat (5) step(12'd1, 1'b1);
    do_reset();
    expect_y(21'd56);
    repeat (8) step(12'd1, 1'b1);
    drain();

    // Long DC run with wrap
    do_reset();
    auto_x = 12'h7FF;
    auto_exp = 1'b1;
    repeat (10000) step(12'h7FF, 1'b1);
    auto_exp = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
